// File: rtl/fis_pkg.sv
// fis_pkg -- shared definitions for the fast inverse square root block.
//   * fis_state_e   : controller state encoding
//   * NR_ITERS_MIN/MAX : legal range of Newton-Raphson step count
//   * FIS_W / FIS_PW   : default word width and full product width
//   * FIS_ITER_CW      : width of the iteration counter (covers NR_ITERS_MAX)
package fis_pkg;

    localparam int FIS_INT_WIDTH_DEF   = 4;
    localparam int FIS_FRACT_WIDTH_DEF = 12;
    localparam int FIS_W               = FIS_INT_WIDTH_DEF + FIS_FRACT_WIDTH_DEF;
    localparam int FIS_PW              = 2 * FIS_W;

    localparam int NR_ITERS_MIN = 1;
    localparam int NR_ITERS_MAX = 4;
    localparam int FIS_ITER_CW  = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEED = 3'd1,
        ST_SQ   = 3'd2,
        ST_MX   = 3'd3,
        ST_UPD  = 3'd4,
        ST_DONE = 3'd5
    } fis_state_e;

endpackage

// File: rtl/fis_seed.sv
// fis_seed -- combinational leading-one detector and initial estimate.
//   x_i    : unsigned operand, Q(INT_WIDTH).(FRACT_WIDTH)
//   seed_o : 2^(-floor(e/2)) where e = msb(x) - FRACT_WIDTH, clamped to
//            [1 LSB, all-ones]. Value is meaningless for x_i == 0; the
//            controller handles that case separately.
module fis_seed
    import fis_pkg::*;
#(
    parameter int INT_WIDTH   = FIS_INT_WIDTH_DEF,
    parameter int FRACT_WIDTH = FIS_FRACT_WIDTH_DEF
) (
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x_i,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] seed_o
);

    localparam int W = INT_WIDTH + FRACT_WIDTH;

    int msb;
    int e_exp;
    int half_e;
    int sh;

    always_comb begin
        msb = 0;
        for (int i = 0; i < W; i++) begin
            if (x_i[i]) msb = i;
        end
        e_exp  = msb - FRACT_WIDTH;
        // Arithmetic shift on a signed int rounds toward minus infinity.
        half_e = e_exp >>> 1;
        // Bit position of the seed's single 1 in the fixed-point word.
        sh     = FRACT_WIDTH - half_e;

        seed_o = '0;
        if (sh >= W) begin
            seed_o = '1;
        end else if (sh < 0) begin
            seed_o[0] = 1'b1;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (i == sh) seed_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_inv_sqrt_iter.sv
// fast_inv_sqrt_iter -- iterative 1/sqrt(x) in unsigned fixed point.
// One operand in flight; a single W x W multiplier is time-shared across
// the three Newton-Raphson sub-steps (y*y, x/2*t, y*(1.5-t)).
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (ready only when idle)
//   x                     : operand Q(INT_WIDTH).(FRACT_WIDTH)
//   out_valid / out_ready : result handshake
//   y                     : 1/sqrt(x), same Q format
//   err                   : x was zero (y = all-ones)
//
// Build option: define FIS_ROUND_EN to round half-up on every product
// re-quantisation; otherwise products are truncated.
module fast_inv_sqrt_iter
    import fis_pkg::*;
#(
    parameter int INT_WIDTH   = FIS_INT_WIDTH_DEF,
    parameter int FRACT_WIDTH = FIS_FRACT_WIDTH_DEF,
    parameter int NR_ITERS    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] y,
    output logic                             err
);

    localparam int W  = INT_WIDTH + FRACT_WIDTH;
    localparam int PW = 2 * W;

    localparam logic [W-1:0]  ALL_ONES     = '1;
    localparam logic [W-1:0]  THREE_HALVES = W'(3) << (FRACT_WIDTH - 1);
    localparam logic [FIS_ITER_CW-1:0] LAST_ITER = FIS_ITER_CW'(NR_ITERS - 1);

    if (NR_ITERS < NR_ITERS_MIN || NR_ITERS > NR_ITERS_MAX) begin : g_bad_nr_iters
        $error("fast_inv_sqrt_iter: NR_ITERS out of range");
    end

    fis_state_e               state_q, state_d;
    logic [W-1:0]             x_q, x_d;
    logic [W-1:0]             y_q, y_d;
    logic [W-1:0]             t_q, t_d;
    logic [FIS_ITER_CW-1:0]   iter_q, iter_d;
    logic                     err_q, err_d;
    logic                     out_valid_q, out_valid_d;

    logic [W-1:0]  seed;
    logic [W-1:0]  term;
    logic [W-1:0]  mul_a, mul_b;
    logic          mul_sh1;
    logic [PW-1:0] mul_p;
    logic [PW:0]   mul_sum;
    logic [PW:0]   mul_shr;
    logic [W-1:0]  mul_q;

    fis_seed #(
        .INT_WIDTH   (INT_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_seed (
        .x_i    (x_q),
        .seed_o (seed)
    );

    // 1.5 - t, clamped at zero when t exceeds 1.5.
    assign term = (t_q > THREE_HALVES) ? '0 : (THREE_HALVES - t_q);

    // Shared multiplier. x_q is used directly as x/2 with one extra fraction
    // bit, so the MX product carries FRACT_WIDTH+1 extra fraction bits.
    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        mul_sh1 = 1'b0;
        case (state_q)
            ST_SQ: begin
                mul_a = y_q;
                mul_b = y_q;
            end
            ST_MX: begin
                mul_a   = x_q;
                mul_b   = t_q;
                mul_sh1 = 1'b1;
            end
            ST_UPD: begin
                mul_a = y_q;
                mul_b = term;
            end
            default: ;
        endcase
    end

    assign mul_p = mul_a * mul_b;

`ifdef FIS_ROUND_EN
    // Half-LSB of the retained result; the extra top bit absorbs the carry.
    assign mul_sum = {1'b0, mul_p} + (mul_sh1 ? ((PW+1)'(1) << FRACT_WIDTH)
                                              : ((PW+1)'(1) << (FRACT_WIDTH - 1)));
`else
    assign mul_sum = {1'b0, mul_p};
`endif

    assign mul_shr = mul_sh1 ? (mul_sum >> (FRACT_WIDTH + 1)) : (mul_sum >> FRACT_WIDTH);
    assign mul_q   = (|mul_shr[PW:W]) ? ALL_ONES : mul_shr[W-1:0];

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        t_d         = t_q;
        iter_d      = iter_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_d     = x;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_SEED;
                end
            end
            ST_SEED: begin
                if (x_q == '0) begin
                    y_d     = ALL_ONES;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    y_d     = seed;
                    state_d = ST_SQ;
                end
            end
            ST_SQ: begin
                t_d     = mul_q;
                state_d = ST_MX;
            end
            ST_MX: begin
                t_d     = mul_q;
                state_d = ST_UPD;
            end
            ST_UPD: begin
                y_d = mul_q;
                if (iter_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end else begin
                    iter_d  = iter_q + 1'b1;
                    state_d = ST_SQ;
                end
            end
            ST_DONE: begin
                // out_valid is raised one cycle after entering DONE, then
                // held until the consumer takes the result.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            t_q         <= '0;
            iter_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            t_q         <= t_d;
            iter_q      <= iter_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fast_inv_sqrt_iter.sv
// Testbench for fast_inv_sqrt_iter. Two instances: default parameters and
// NR_ITERS=4 (used for slowly converging operands such as 2.0).
module tb_fast_inv_sqrt_iter;

    localparam int W  = fis_pkg::FIS_W;
    localparam int PW = fis_pkg::FIS_PW;
    localparam int F  = fis_pkg::FIS_FRACT_WIDTH_DEF;
    localparam longint unsigned MAXV = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_valid4 = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] x = '0;
    logic         in_ready, in_ready4, out_valid, out_valid4, err, err4;
    logic [W-1:0] y, y4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fast_inv_sqrt_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .out_valid(out_valid), .out_ready(out_ready), .y(y), .err(err)
    );

    fast_inv_sqrt_iter #(.NR_ITERS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .x(x), .out_valid(out_valid4), .out_ready(out_ready), .y(y4), .err(err4)
    );

    // Re-quantise a product carrying s extra fraction bits.
    function automatic longint unsigned rq(input logic [PW:0] p, input int s);
        longint unsigned v;
        v = longint'(p);
`ifdef FIS_ROUND_EN
        v = v + (64'd1 << (s - 1));
`endif
        v = v >> s;
        return (v > MAXV) ? MAXV : v;
    endfunction

    // Reference: seed from exponent, then nr Newton steps y*(1.5 - x/2*y^2).
    function automatic void model(input logic [W-1:0] xv, input int nr,
                                  output logic [W-1:0] yv, output logic ev);
        longint unsigned yy, t, xh_num, term;
        int p, e, fl, sh;
        if (xv == 0) begin
            yv = W'(MAXV);
            ev = 1'b1;
            return;
        end
        p = 0;
        for (int i = 0; i < W; i++) if (xv[i]) p = i;
        e  = p - F;
        fl = (e >= 0) ? (e / 2) : -((1 - e) / 2);
        sh = F - fl;
        if (sh >= W)     yy = MAXV;
        else if (sh < 0) yy = 1;
        else             yy = 64'd1 << sh;
        xh_num = longint'(xv);   // x/2 = xv / 2^(F+1)
        for (int k = 0; k < nr; k++) begin
            t    = rq((PW+1)'(yy * yy), F);
            t    = rq((PW+1)'(xh_num * t), F + 1);
            term = (t > 3 * (64'd1 << (F - 1))) ? 0 : 3 * (64'd1 << (F - 1)) - t;
            yy   = rq((PW+1)'(yy * term), F);
        end
        yv = W'(yy);
        ev = 1'b0;
    endfunction

    // Present one operand, wait (bounded) for the result, then hand it off.
    // lat = edges from the accepting edge to out_valid, -1 on timeout.
    task automatic do_op(input logic [W-1:0] xv, input bit use4,
                         output logic [W-1:0] yv, output logic ev, output int lat);
        @(negedge clk);
        x = xv;
        if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid4 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if ((use4 ? out_valid4 : out_valid) === 1'b1) begin
                lat = c;
                break;
            end
        end
        yv = use4 ? y4 : y;
        ev = use4 ? err4 : err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %h exp 0000", y); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || y4 !== '0) begin
            errors++; $display("FAIL reset_dut4 got rdy %b vld %b y %h exp 1 0 0000", in_ready4, out_valid4, y4);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] xs [4] = '{16'h4000, 16'h1000, 16'h0400, 16'h0000};
        logic [W-1:0] ye [4] = '{16'h0800, 16'h1000, 16'h2000, 16'hFFFF};
        logic [W-1:0] yv, ym;
        logic ev, em;
        int lat, le;
        for (int i = 0; i < 4; i++) begin
            do_op(xs[i], 1'b0, yv, ev, lat);
            model(xs[i], 2, ym, em);
            le = (xs[i] == 0) ? 2 : 8;
            checks++; if (yv !== ye[i]) begin errors++; $display("FAIL directed_y x=%h got %h exp %h", xs[i], yv, ye[i]); end
            checks++; if (yv !== ym) begin errors++; $display("FAIL directed_model x=%h got %h exp %h", xs[i], yv, ym); end
            checks++; if (ev !== (xs[i] == 0)) begin errors++; $display("FAIL directed_err x=%h got %b exp %b", xs[i], ev, xs[i] == 0); end
            checks++; if (lat != le) begin errors++; $display("FAIL directed_lat x=%h got %0d exp %0d", xs[i], lat, le); end
        end
    endtask

    task automatic test_sqrt2();
        logic [W-1:0] yv, ym;
        logic ev, em;
        int lat;
        do_op(16'h2000, 1'b1, yv, ev, lat);
        model(16'h2000, 4, ym, em);
        checks++; if (yv !== ym || ev !== em) begin errors++; $display("FAIL sqrt2_model got %h/%b exp %h/%b", yv, ev, ym, em); end
        checks++; if (lat != 14) begin errors++; $display("FAIL sqrt2_lat got %0d exp 14", lat); end
`ifdef FIS_ROUND_EN
        checks++; if (yv < 16'h0B4F || yv > 16'h0B51) begin errors++; $display("FAIL sqrt2_window got %h exp 0B50+/-1", yv); end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] xv, yv, ym;
        logic ev, em;
        int lat, nr;
        bit use4;
        for (int i = 0; i < 32; i++) begin
            use4 = (i % 4 == 3);
            nr   = use4 ? 4 : 2;
            xv   = W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            if (i == 5) xv = '0;
            if (i == 6) xv = 16'hFFFF;
            if (i == 7) xv = 16'h0001;
            do_op(xv, use4, yv, ev, lat);
            model(xv, nr, ym, em);
            checks++; if (yv !== ym || ev !== em) begin errors++; $display("FAIL random_y x=%h nr=%0d got %h/%b exp %h/%b", xv, nr, yv, ev, ym, em); end
            checks++; if (lat != ((xv == 0) ? 2 : 2 + 3 * nr)) begin errors++; $display("FAIL random_lat x=%h got %0d exp %0d", xv, lat, (xv == 0) ? 2 : 2 + 3 * nr); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        x = 16'h1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin lat = c; break; end
        end
        checks++; if (lat != 8) begin errors++; $display("FAIL bp_lat got %0d exp 8", lat); end
        // Second operand offered while the first result is stalled.
        x = 16'h4000; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || y !== 16'h1000 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc %0d got vld %b y %h rdy %b exp 1 1000 0", c, out_valid, y, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== 16'h1000) begin
            errors++; $display("FAIL bp_release got vld %b rdy %b y %h exp 0 1 1000", out_valid, in_ready, y);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept got rdy %b exp 0", in_ready); end
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin lat = c; break; end
        end
        checks++; if (lat != 8 || y !== 16'h0800) begin errors++; $display("FAIL bp_second got lat %0d y %h exp 8 0800", lat, y); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] yv;
        logic ev;
        int lat;
        @(negedge clk);
        x = 16'h4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end   // now in MX
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_hs got vld %b rdy %b exp 0 1", out_valid, in_ready);
        end
        checks++; if (y !== '0 || err !== 1'b0) begin errors++; $display("FAIL midrst_y got %h/%b exp 0000/0", y, err); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h4000, 1'b0, yv, ev, lat);
        checks++; if (yv !== 16'h0800 || ev !== 1'b0 || lat != 8) begin
            errors++; $display("FAIL midrst_next got %h/%b lat %0d exp 0800/0 8", yv, ev, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sqrt2();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
